// File: rtl/dmem_pkg.sv
// Shared definitions for the data-cache controller: access codes, FSM states, line geometry.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmem_pkg;

  // READ_WRITE access codes; anything not listed behaves as idle
  localparam logic [3:0] RW_IDLE = 4'b0000;
  localparam logic [3:0] RW_LB   = 4'b1000;
  localparam logic [3:0] RW_LH   = 4'b1001;
  localparam logic [3:0] RW_LW   = 4'b1010;
  localparam logic [3:0] RW_LBU  = 4'b1100;
  localparam logic [3:0] RW_LHU  = 4'b1101;
  localparam logic [3:0] RW_SB   = 4'b0001;
  localparam logic [3:0] RW_SH   = 4'b0010;
  localparam logic [3:0] RW_SW   = 4'b0011;

  localparam int LINE_WORDS = 4;
  localparam int LINE_BITS  = 128;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2,
    ST_FILL      = 2'd3
  } state_t;

  function automatic logic is_load(input logic [3:0] code);
    case (code)
      RW_LB, RW_LH, RW_LW, RW_LBU, RW_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] code);
    case (code)
      RW_SB, RW_SH, RW_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte/halfword lane steering: extends loads, merges stores, flags misalignment.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs. Ports: rw_code/offset/line_word/store_data in; load_data/merged_word/misaligned out.
module load_store_align
  import dmem_pkg::*;
(
  input  logic [3:0]  rw_code,
  input  logic [1:0]  offset,
  input  logic [31:0] line_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word,
  output logic        misaligned
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = line_word[7:0];
    case (offset)
      2'd0:    sel_byte = line_word[7:0];
      2'd1:    sel_byte = line_word[15:8];
      2'd2:    sel_byte = line_word[23:16];
      default: sel_byte = line_word[31:24];
    endcase
  end

  // offset[0] is ignored here; a halfword with offset[0]=1 is flagged misaligned
  assign sel_half = offset[1] ? line_word[31:16] : line_word[15:0];

  always_comb begin
    misaligned  = 1'b0;
    load_data   = '0;
    merged_word = line_word;
    case (rw_code)
      RW_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
      RW_LBU: load_data = {24'b0, sel_byte};
      RW_LH: begin
        misaligned = offset[0];
        load_data  = {{16{sel_half[15]}}, sel_half};
      end
      RW_LHU: begin
        misaligned = offset[0];
        load_data  = {16'b0, sel_half};
      end
      RW_LW: begin
        misaligned = |offset;
        load_data  = line_word;
      end
      RW_SB: merged_word[{offset, 3'b000} +: 8] = store_data[7:0];
      RW_SH: begin
        misaligned = offset[0];
        merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
      end
      RW_SW: begin
        misaligned  = |offset;
        merged_word = store_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache with 4-word lines; ports: CPU side ADDRESS/WRITE_DATA/READ_WRITE -> READ_DATA/BUSYWAIT/MISALIGNED, memory side MEM_* line interface.
// Latency: hits complete in the request cycle; clean miss = 1 + mem cycles + 1, dirty miss adds the writeback cycles.
// Backpressure: BUSYWAIT freezes the pipeline during a miss; MEM_BUSYWAIT stretches WRITEBACK/ALLOCATE until it drops.
module dcache_ctrl
  import dmem_pkg::*;
#(
  parameter int INDEX_BITS = 3
)
(
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          ADDRESS,
  input  logic [31:0]          WRITE_DATA,
  input  logic [3:0]           READ_WRITE,
  output logic [31:0]          READ_DATA,
  output logic                 BUSYWAIT,
  output logic                 MISALIGNED,
  output logic                 MEM_READ,
  output logic                 MEM_WRITE,
  output logic [27:0]          MEM_ADDRESS,
  output logic [LINE_BITS-1:0] MEM_WRITEDATA,
  input  logic [LINE_BITS-1:0] MEM_READDATA,
  input  logic                 MEM_BUSYWAIT
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;
  localparam int WSEL     = $clog2(LINE_WORDS);

  logic [1:0]            offset;
  logic [WSEL-1:0]       word_sel;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;

  assign offset   = ADDRESS[1:0];
  assign word_sel = ADDRESS[3:2];
  assign idx      = ADDRESS[3+INDEX_BITS:4];
  assign tag      = ADDRESS[31:4+INDEX_BITS];

  logic [LINE_BITS-1:0] data_arr [LINES];
  logic [TAG_BITS-1:0]  tag_arr  [LINES];
  logic [LINES-1:0]     valid_arr;
  logic [LINES-1:0]     dirty_arr;
  logic [LINE_BITS-1:0] fill_buf;

  state_t state, state_nxt;

  logic [31:0] cur_word, ld_word, st_word;
  logic        mis, access, hit, store_hit;

  assign cur_word = data_arr[idx][{word_sel, 5'b00000} +: 32];

  load_store_align u_align (
    .rw_code     (READ_WRITE),
    .offset      (offset),
    .line_word   (cur_word),
    .store_data  (WRITE_DATA),
    .load_data   (ld_word),
    .merged_word (st_word),
    .misaligned  (mis)
  );

  // misaligned accesses are dropped entirely: no lookup, no stall
  assign access    = (is_load(READ_WRITE) | is_store(READ_WRITE)) & ~mis;
  assign hit       = valid_arr[idx] && (tag_arr[idx] == tag);
  assign store_hit = (state == ST_IDLE) && is_store(READ_WRITE) && !mis && hit;

  assign MISALIGNED    = mis;
  assign READ_DATA     = ((state == ST_IDLE) && is_load(READ_WRITE) && !mis && hit) ? ld_word : 32'd0;
  assign MEM_WRITEDATA = data_arr[idx];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      valid_arr <= '0;
      dirty_arr <= '0;
    end else begin
      state <= state_nxt;
      if (store_hit) dirty_arr[idx] <= 1'b1;
      if (state == ST_FILL) begin
        valid_arr[idx] <= 1'b1;
        dirty_arr[idx] <= 1'b0;
      end
    end
  end

  // Line storage carries no reset; validity alone gates its use
  always_ff @(posedge CLK) begin
    if (state == ST_ALLOCATE && !MEM_BUSYWAIT) fill_buf <= MEM_READDATA;
    if (store_hit) data_arr[idx][{word_sel, 5'b00000} +: 32] <= st_word;
    if (state == ST_FILL) begin
      data_arr[idx] <= fill_buf;
      tag_arr[idx]  <= tag;
    end
  end

  always_comb begin
    state_nxt   = state;
    BUSYWAIT    = 1'b0;
    MEM_READ    = 1'b0;
    MEM_WRITE   = 1'b0;
    MEM_ADDRESS = ADDRESS[31:4];
    case (state)
      ST_IDLE: begin
        if (access && !hit) begin
          BUSYWAIT  = 1'b1;
          state_nxt = dirty_arr[idx] ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        BUSYWAIT    = 1'b1;
        MEM_WRITE   = 1'b1;
        MEM_ADDRESS = {tag_arr[idx], idx};
        if (!MEM_BUSYWAIT) state_nxt = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        BUSYWAIT = 1'b1;
        MEM_READ = 1'b1;
        if (!MEM_BUSYWAIT) state_nxt = ST_FILL;
      end
      ST_FILL: begin
        // the stalled access replays as a hit in IDLE on the next cycle
        BUSYWAIT  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
